lif_spike_monitor: RTL and testbench

Downstream stage of tt_um_lif. It consumes the neuron's spike output (uio_out[7]) and 8-bit membrane state (uo_out) and produces per-window spike counts, per-window peak membrane state, inter-spike intervals (ISI) and a burst flag. Results feed on-chip debug readout and the characterisation benches.

---
 rtl/lif_spike_monitor.sv | 202 ++++++++++++++++++++
 tb/tb_lif_spike_monitor.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_spike_monitor.sv
// lif_spike_monitor: observes the LIF neuron spike/membrane outputs and
// produces per-window spike counts and peak state, inter-spike intervals
// and a burst flag. All state advances only on enabled cycles.
module lif_spike_monitor #(
    parameter int WINDOW_CYCLES = 256,
    parameter int CNT_W         = 8,
    parameter int ISI_W         = 12,
    parameter int BURST_ISI     = 4,
    parameter int BURST_MIN     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             spike_in,
    input  logic [7:0]       state_in,
    output logic [CNT_W-1:0] win_count,
    output logic             win_sat,
    output logic [7:0]       win_peak,
    output logic             win_valid,
    output logic [ISI_W-1:0] isi,
    output logic             isi_valid,
    output logic             burst
);

    localparam int WC_W  = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int RUN_W = (BURST_MIN >= 1) ? $clog2(BURST_MIN + 1) : 1;

    localparam logic [WC_W-1:0]  WC_LAST   = WC_W'(WINDOW_CYCLES - 1);
    localparam logic [ISI_W-1:0] ISI_SHORT = ISI_W'(BURST_ISI);
    localparam logic [RUN_W-1:0] RUN_MIN   = RUN_W'(BURST_MIN);

    // Saturating increment of the window spike counter.
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Saturating increment of the inter-spike timer.
    function automatic logic [ISI_W-1:0] isi_sat_inc(input logic [ISI_W-1:0] v);
        return (v == {ISI_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Run of short ISIs only needs to count up to the burst threshold.
    function automatic logic [RUN_W-1:0] run_sat_inc(input logic [RUN_W-1:0] v);
        return (v >= RUN_MIN) ? v : v + 1'b1;
    endfunction

    function automatic logic [7:0] peak_max(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [WC_W-1:0]  wc_q, wc_d;
    logic             spike_prev_q, spike_prev_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic             acc_sat_q, acc_sat_d;
    logic [7:0]       acc_peak_q, acc_peak_d;
    logic [ISI_W-1:0] timer_q, timer_d;
    logic             first_q, first_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] win_count_q, win_count_d;
    logic             win_sat_q, win_sat_d;
    logic [7:0]       win_peak_q, win_peak_d;
    logic             win_valid_q, win_valid_d;
    logic [ISI_W-1:0] isi_q, isi_d;
    logic             isi_valid_q, isi_valid_d;
    logic             burst_q, burst_d;

    logic             evt;
    logic             term;
    logic [CNT_W-1:0] cnt_nx;
    logic             sat_nx;
    logic [7:0]       peak_nx;
    logic [RUN_W-1:0] run_nx;

    // A held-high spike counts once: only the enabled rising edge is an event.
    assign evt  = ena & spike_in & ~spike_prev_q;
    assign term = ena & (wc_q == WC_LAST);

    // Next-state logic for window accumulation, ISI timing and burst tracking.
    always_comb begin
        cnt_nx       = acc_cnt_q;
        sat_nx       = acc_sat_q;
        peak_nx      = acc_peak_q;
        run_nx       = run_sat_inc(run_q);

        wc_d         = wc_q;
        spike_prev_d = spike_prev_q;
        acc_cnt_d    = acc_cnt_q;
        acc_sat_d    = acc_sat_q;
        acc_peak_d   = acc_peak_q;
        timer_d      = timer_q;
        first_d      = first_q;
        run_d        = run_q;
        win_count_d  = win_count_q;
        win_sat_d    = win_sat_q;
        win_peak_d   = win_peak_q;
        win_valid_d  = 1'b0;
        isi_d        = isi_q;
        isi_valid_d  = 1'b0;
        burst_d      = burst_q;

        if (ena) begin
            spike_prev_d = spike_in;
            wc_d         = term ? '0 : wc_q + 1'b1;

            // The terminal cycle's own event and state are part of the window.
            if (evt) begin
                if (acc_cnt_q == {CNT_W{1'b1}}) begin
                    sat_nx = 1'b1;
                end else begin
                    cnt_nx = cnt_sat_inc(acc_cnt_q);
                end
            end
            peak_nx = peak_max(acc_peak_q, state_in);

            if (term) begin
                win_count_d = cnt_nx;
                win_sat_d   = sat_nx;
                win_peak_d  = peak_nx;
                win_valid_d = 1'b1;
                acc_cnt_d   = '0;
                acc_sat_d   = 1'b0;
                acc_peak_d  = '0;
            end else begin
                acc_cnt_d   = cnt_nx;
                acc_sat_d   = sat_nx;
                acc_peak_d  = peak_nx;
            end

            // The timer value at an event is the interval since the previous one.
            if (evt) begin
                timer_d = ISI_W'(1);
                first_d = 1'b1;
                if (first_q) begin
                    isi_d       = timer_q;
                    isi_valid_d = 1'b1;
                    if (timer_q <= ISI_SHORT) begin
                        run_d = run_nx;
                        if (run_nx >= RUN_MIN) begin
                            burst_d = 1'b1;
                        end
                    end else begin
                        run_d   = '0;
                        burst_d = 1'b0;
                    end
                end
            end else begin
                timer_d = isi_sat_inc(timer_q);
                // Silence longer than a short ISI ends any burst in progress.
                if (timer_q > ISI_SHORT) begin
                    run_d   = '0;
                    burst_d = 1'b0;
                end
            end
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wc_q         <= '0;
            spike_prev_q <= 1'b0;
            acc_cnt_q    <= '0;
            acc_sat_q    <= 1'b0;
            acc_peak_q   <= '0;
            timer_q      <= '0;
            first_q      <= 1'b0;
            run_q        <= '0;
            win_count_q  <= '0;
            win_sat_q    <= 1'b0;
            win_peak_q   <= '0;
            win_valid_q  <= 1'b0;
            isi_q        <= '0;
            isi_valid_q  <= 1'b0;
            burst_q      <= 1'b0;
        end else begin
            wc_q         <= wc_d;
            spike_prev_q <= spike_prev_d;
            acc_cnt_q    <= acc_cnt_d;
            acc_sat_q    <= acc_sat_d;
            acc_peak_q   <= acc_peak_d;
            timer_q      <= timer_d;
            first_q      <= first_d;
            run_q        <= run_d;
            win_count_q  <= win_count_d;
            win_sat_q    <= win_sat_d;
            win_peak_q   <= win_peak_d;
            win_valid_q  <= win_valid_d;
            isi_q        <= isi_d;
            isi_valid_q  <= isi_valid_d;
            burst_q      <= burst_d;
        end
    end

    assign win_count = win_count_q;
    assign win_sat   = win_sat_q;
    assign win_peak  = win_peak_q;
    assign win_valid = win_valid_q;
    assign isi       = isi_q;
    assign isi_valid = isi_valid_q;
    assign burst     = burst_q;

endmodule

// File: tb/tb_lif_spike_monitor.sv
// Directed bench for lif_spike_monitor: a 16-cycle-window instance for the
// window/ISI/burst/gating scenarios and a 24-cycle, 3-bit-count instance
// for counter saturation. Both share the same stimulus.
module tb_lif_spike_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        spike_in;
    logic [7:0]  state_in;

    logic [7:0]  d_win_count;
    logic        d_win_sat;
    logic [7:0]  d_win_peak;
    logic        d_win_valid;
    logic [11:0] d_isi;
    logic        d_isi_valid;
    logic        d_burst;

    logic [2:0]  s_win_count;
    logic        s_win_sat;
    logic [7:0]  s_win_peak;
    logic        s_win_valid;
    logic [11:0] s_isi;
    logic        s_isi_valid;
    logic        s_burst;

    int checks = 0;
    int errors = 0;

    lif_spike_monitor #(
        .WINDOW_CYCLES(16), .CNT_W(8), .ISI_W(12), .BURST_ISI(4), .BURST_MIN(2)
    ) u_dut (
        .clk(clk), .rst(rst), .ena(ena), .spike_in(spike_in), .state_in(state_in),
        .win_count(d_win_count), .win_sat(d_win_sat), .win_peak(d_win_peak),
        .win_valid(d_win_valid), .isi(d_isi), .isi_valid(d_isi_valid), .burst(d_burst)
    );

    lif_spike_monitor #(
        .WINDOW_CYCLES(24), .CNT_W(3), .ISI_W(12), .BURST_ISI(4), .BURST_MIN(2)
    ) u_sat (
        .clk(clk), .rst(rst), .ena(ena), .spike_in(spike_in), .state_in(state_in),
        .win_count(s_win_count), .win_sat(s_win_sat), .win_peak(s_win_peak),
        .win_valid(s_win_valid), .isi(s_isi), .isi_valid(s_isi_valid), .burst(s_burst)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst      = 1'b1;
        ena      = 1'b1;
        spike_in = 1'b0;
        state_in = 8'h00;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        int first;
        rst      = 1'b1;
        ena      = 1'b1;
        spike_in = 1'b0;
        state_in = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            spike_in = ~spike_in;
            tick();
            checks++;
            if ({d_win_count, d_win_sat, d_win_peak, d_win_valid, d_isi, d_isi_valid, d_burst} !== 31'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got cnt=%0d sat=%0d peak=%0h wv=%0d isi=%0d iv=%0d burst=%0d expected all 0",
                         i, d_win_count, d_win_sat, d_win_peak, d_win_valid, d_isi, d_isi_valid, d_burst);
            end
            checks++;
            if ({s_win_count, s_win_sat, s_win_valid, s_isi_valid, s_burst} !== 7'd0) begin
                errors++;
                $display("FAIL reset_outputs_sat cycle %0d: got cnt=%0d sat=%0d wv=%0d iv=%0d burst=%0d expected all 0",
                         i, s_win_count, s_win_sat, s_win_valid, s_isi_valid, s_burst);
            end
        end
        rst      = 1'b0;
        spike_in = 1'b0;
        state_in = 8'h00;
        first    = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (d_win_valid) begin
                first = k;
                break;
            end
        end
        checks++;
        if (first !== 16) begin
            errors++;
            $display("FAIL reset_first_window: got win_valid after %0d cycles expected 16", first);
        end
        checks++;
        if (d_win_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_first_count: got %0d expected 0", d_win_count);
        end
    endtask

    task automatic test_window_held;
        int wc;
        do_reset();
        for (int k = 1; k <= 32; k++) begin
            wc = (k - 1) % 16;
            if (k <= 16) begin
                spike_in = ((wc >= 2) && (wc <= 4)) || (wc == 10);
                state_in = (wc == 7) ? 8'hC8 : 8'(wc * 8);
            end else begin
                spike_in = 1'b0;
                state_in = 8'h10;
            end
            tick();
            if (k == 16) begin
                checks++;
                if (d_win_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL held_valid: got %0d expected 1", d_win_valid);
                end
                checks++;
                if (d_win_count !== 8'd2) begin
                    errors++;
                    $display("FAIL held_count: got %0d expected 2", d_win_count);
                end
                checks++;
                if (d_win_peak !== 8'hC8) begin
                    errors++;
                    $display("FAIL held_peak: got %0h expected c8", d_win_peak);
                end
                checks++;
                if (d_win_sat !== 1'b0) begin
                    errors++;
                    $display("FAIL held_sat: got %0d expected 0", d_win_sat);
                end
            end
            if (k == 17) begin
                checks++;
                if (d_win_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL held_pulse_width: got %0d expected 0", d_win_valid);
                end
            end
            if (k == 32) begin
                checks++;
                if ({d_win_valid, d_win_count, d_win_peak} !== {1'b1, 8'd0, 8'h10}) begin
                    errors++;
                    $display("FAIL held_next_window: got valid=%0d cnt=%0d peak=%0h expected valid=1 cnt=0 peak=10",
                             d_win_valid, d_win_count, d_win_peak);
                end
            end
        end
    endtask

    task automatic test_terminal_event;
        do_reset();
        for (int k = 1; k <= 32; k++) begin
            spike_in = (k == 16);
            state_in = 8'h00;
            tick();
            if (k == 16) begin
                checks++;
                if ({d_win_valid, d_win_count} !== {1'b1, 8'd1}) begin
                    errors++;
                    $display("FAIL terminal_count: got valid=%0d cnt=%0d expected valid=1 cnt=1", d_win_valid, d_win_count);
                end
            end
            if (k == 32) begin
                checks++;
                if ({d_win_valid, d_win_count} !== {1'b1, 8'd0}) begin
                    errors++;
                    $display("FAIL terminal_next: got valid=%0d cnt=%0d expected valid=1 cnt=0", d_win_valid, d_win_count);
                end
            end
        end
    endtask

    task automatic test_saturation;
        do_reset();
        for (int k = 1; k <= 48; k++) begin
            spike_in = (k <= 20) && ((k % 2) == 1);
            state_in = 8'h00;
            tick();
            if (k == 16) begin
                checks++;
                if ({d_win_count, d_win_sat} !== {8'd8, 1'b0}) begin
                    errors++;
                    $display("FAIL sat_wide_count: got cnt=%0d sat=%0d expected cnt=8 sat=0", d_win_count, d_win_sat);
                end
            end
            if (k == 24) begin
                checks++;
                if ({s_win_valid, s_win_count, s_win_sat} !== {1'b1, 3'd7, 1'b1}) begin
                    errors++;
                    $display("FAIL sat_count: got valid=%0d cnt=%0d sat=%0d expected valid=1 cnt=7 sat=1",
                             s_win_valid, s_win_count, s_win_sat);
                end
            end
            if (k == 48) begin
                checks++;
                if ({s_win_valid, s_win_count, s_win_sat} !== {1'b1, 3'd0, 1'b0}) begin
                    errors++;
                    $display("FAIL sat_clear: got valid=%0d cnt=%0d sat=%0d expected valid=1 cnt=0 sat=0",
                             s_win_valid, s_win_count, s_win_sat);
                end
            end
        end
    endtask

    task automatic test_isi_burst;
        logic        exp_v;
        logic        exp_b;
        logic [11:0] exp_isi;
        do_reset();
        for (int k = 1; k <= 36; k++) begin
            spike_in = (k == 5) || (k == 8) || (k == 11) || (k == 14) || (k == 30);
            state_in = 8'h00;
            tick();
            exp_v   = (k == 8) || (k == 11) || (k == 14) || (k == 30);
            exp_b   = (k >= 11) && (k < 19);
            exp_isi = (k == 30) ? 12'd16 : 12'd3;
            checks++;
            if (d_isi_valid !== exp_v) begin
                errors++;
                $display("FAIL isi_valid cycle %0d: got %0d expected %0d", k, d_isi_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (d_isi !== exp_isi) begin
                    errors++;
                    $display("FAIL isi_value cycle %0d: got %0d expected %0d", k, d_isi, exp_isi);
                end
            end
            checks++;
            if (d_burst !== exp_b) begin
                errors++;
                $display("FAIL burst cycle %0d: got %0d expected %0d", k, d_burst, exp_b);
            end
        end
    endtask

    task automatic test_ena_gating;
        do_reset();
        state_in = 8'h20;
        for (int k = 1; k <= 5; k++) begin
            spike_in = (k == 4);
            tick();
        end
        ena      = 1'b0;
        spike_in = 1'b1;
        state_in = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({d_win_valid, d_isi_valid, d_win_count, d_isi} !== {1'b0, 1'b0, 8'd0, 12'd0}) begin
                errors++;
                $display("FAIL gate_frozen cycle %0d: got wv=%0d iv=%0d cnt=%0d isi=%0d expected all 0",
                         i, d_win_valid, d_isi_valid, d_win_count, d_isi);
            end
        end
        ena      = 1'b1;
        state_in = 8'h20;
        for (int k = 6; k <= 16; k++) begin
            spike_in = (k <= 8);
            tick();
            if (k == 6) begin
                checks++;
                if ({d_isi_valid, d_isi} !== {1'b1, 12'd2}) begin
                    errors++;
                    $display("FAIL gate_isi: got iv=%0d isi=%0d expected iv=1 isi=2", d_isi_valid, d_isi);
                end
            end
            if ((k == 7) || (k == 8)) begin
                checks++;
                if (d_isi_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL gate_held_once cycle %0d: got iv=%0d expected 0", k, d_isi_valid);
                end
            end
            if (k == 15) begin
                checks++;
                if (d_win_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL gate_early_window: got %0d expected 0", d_win_valid);
                end
            end
            if (k == 16) begin
                checks++;
                if ({d_win_valid, d_win_count, d_win_peak} !== {1'b1, 8'd2, 8'h20}) begin
                    errors++;
                    $display("FAIL gate_window: got valid=%0d cnt=%0d peak=%0h expected valid=1 cnt=2 peak=20",
                             d_win_valid, d_win_count, d_win_peak);
                end
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        ena      = 1'b0;
        spike_in = 1'b0;
        state_in = 8'h00;
        test_reset();
        test_window_held();
        test_terminal_event();
        test_saturation();
        test_isi_burst();
        test_ena_gating();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
